// File: rtl/load_store_unit.sv
// Load/store initiator for a word-addressed, read-registered data memory with no byte enables.
// Optional LSU_RANGE_CHECK_EN flags effective addresses beyond the memory as errors.
module load_store_unit #(
    parameter int ADDR_WIDTH = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_store_data,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_load_data,
    output logic        mem_store,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    localparam int EAW = ADDR_WIDTH + 2;

    state_t          state_q, state_d;
    logic [EAW-1:0]  ea_q, ea_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            store_q, store_d;
    logic            err_q, err_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     ldata_q, ldata_d;

    logic [31:0] ea_req;
    logic        legal, misalign, range_err, req_err;
    logic [4:0]  shamt;
    logic [31:0] rd_shift, lane_mask, merged, load_ext;

    assign ea_req = req_base + req_offset;

    always_comb begin
        if (req_store) legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else           legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
        misalign = ((req_funct3[1:0] == 2'b01) && ea_req[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (ea_req[1:0] != 2'b00));
`ifdef LSU_RANGE_CHECK_EN
        range_err = (ea_req[31:EAW] != '0);
`else
        // Upper address bits are deliberately ignored: addresses alias modulo the memory size.
        range_err = 1'b0 & (|ea_req[31:EAW]);
`endif
        req_err = !legal || misalign || range_err;
    end

    // Little-endian lane handling: byte lane n lives at bits [8n+7:8n].
    assign shamt     = {ea_q[1:0], 3'b000};
    assign rd_shift  = mem_read_data >> shamt;
    assign lane_mask = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
    assign merged    = (mem_read_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_ext = {24'h0, rd_shift[7:0]};
            3'b101:  load_ext = {16'h0, rd_shift[15:0]};
            default: load_ext = mem_read_data;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ea_d     = ea_q;
        funct3_d = funct3_q;
        store_d  = store_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        ldata_d  = ldata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ea_d     = ea_req[EAW-1:0];
                    funct3_d = req_funct3;
                    store_d  = req_store;
                    err_d    = req_err;
                    if (req_err) begin
                        ldata_d = '0;
                        state_d = RESP;
                    end else if (req_store) begin
                        ldata_d = '0;
                        wdata_d = req_store_data;
                        state_d = (req_funct3 == 3'b010) ? WR : RD;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:   state_d = WAIT;
            WAIT: begin
                if (store_q) begin
                    wdata_d = merged;
                    state_d = WR;
                end else begin
                    ldata_d = load_ext;
                    state_d = RESP;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ea_q     <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            ldata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ea_q     <= ea_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            ldata_q  <= ldata_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign resp_error     = (state_q == RESP) && err_q;
    assign resp_load_data = ldata_q;
    assign mem_store      = (state_q == WR);
    assign mem_address    = {{(32-ADDR_WIDTH){1'b0}}, ea_q[EAW-1:2]};
    assign mem_write_data = wdata_q;

endmodule
